rob_param: RTL and testbench

- Parametrised reorder buffer for the Tomasulo core. Sits between dispatch, the two result buses (ALU CDB, LSB CDB), the LSB store-commit path, the register file and the branch predictor.
- Improvements over the previous generation:
  - depth is a parameter, and all DEPTH entries are usable (full/empty come from an occupancy counter);
  - operand lookup bypasses same-cycle CDB results;
  - stores retire only after an explicit LSB handshake.
- Entry tags are idx+1, so tag 0 always means "no dependency".

---
 rtl/rob_param.sv | 217 +++++++++++++++++++++
 tb/tb_rob_param.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order commit of out-of-order results, with CDB
// bypass on operand lookup, handshaked store retirement and branch misprediction recovery.
module rob_param #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH + 1),
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  output logic             full,
  input  logic             alloc_valid,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic [REG_W-1:0] alloc_rd,
  input  logic             alloc_is_branch,
  input  logic             alloc_is_store,
  input  logic             alloc_pred_taken,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic [TAG_W-1:0] qa_tag,
  input  logic [TAG_W-1:0] qb_tag,
  output logic             qa_ready,
  output logic             qb_ready,
  output logic [XLEN-1:0]  qa_data,
  output logic [XLEN-1:0]  qb_data,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             alu_taken,
  input  logic [XLEN-1:0]  alu_target,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [XLEN-1:0]  lsb_data,
  output logic             st_commit_req,
  output logic [TAG_W-1:0] st_commit_tag,
  input  logic             st_done,
  output logic             rf_valid,
  output logic [REG_W-1:0] rf_rd,
  output logic [TAG_W-1:0] rf_tag,
  output logic [XLEN-1:0]  rf_data,
  output logic             bp_valid,
  output logic [XLEN-1:0]  bp_pc,
  output logic             bp_taken,
  output logic             flush,
  output logic [XLEN-1:0]  flush_pc
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] ready_q, ready_d;

  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [REG_W-1:0] rd_q     [DEPTH];
  logic [XLEN-1:0]  data_q   [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic             br_q     [DEPTH];
  logic             st_q     [DEPTH];
  logic             pred_q   [DEPTH];
  logic             taken_q  [DEPTH];

  logic             rf_valid_q, rf_valid_d;
  logic [REG_W-1:0] rf_rd_q, rf_rd_d;
  logic [TAG_W-1:0] rf_tag_q, rf_tag_d;
  logic [XLEN-1:0]  rf_data_q, rf_data_d;
  logic             bp_valid_q, bp_valid_d;
  logic [XLEN-1:0]  bp_pc_q, bp_pc_d;
  logic             bp_taken_q, bp_taken_d;
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  flush_pc_q, flush_pc_d;

  logic             alloc_fire, alu_hit, lsb_hit;
  logic [IDX_W-1:0] alu_idx, lsb_idx;
  logic [TAG_W-1:0] head_tag;
  logic             non_empty, st_retire, norm_commit, commit;

  assign full       = (count_q == TAG_W'(DEPTH));
  assign alloc_tag  = TAG_W'(tail_q) + TAG_W'(1);
  assign head_tag   = TAG_W'(head_q) + TAG_W'(1);
  assign alloc_fire = alloc_valid && !full;
  assign alu_hit    = alu_valid && (alu_tag != '0);
  assign lsb_hit    = lsb_valid && (lsb_tag != '0);
  assign alu_idx    = IDX_W'(alu_tag - TAG_W'(1));
  assign lsb_idx    = IDX_W'(lsb_tag - TAG_W'(1));

  // A store at the head waits for the LSB; st_done retires it without an RF write.
  assign non_empty     = (count_q != '0);
  assign st_commit_req = non_empty && st_q[head_q] && !ready_q[head_q];
  assign st_commit_tag = head_tag;
  assign st_retire     = st_commit_req && st_done;
  assign norm_commit   = non_empty && ready_q[head_q];
  assign commit        = norm_commit || st_retire;

  // Same-cycle CDB results take priority over stored values (ALU over LSB).
  function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] q);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(q - TAG_W'(1));
    if (q == '0)                        lookup = '0;
    else if (alu_valid && alu_tag == q) lookup = {1'b1, alu_data};
    else if (lsb_valid && lsb_tag == q) lookup = {1'b1, lsb_data};
    else                                lookup = {ready_q[idx], data_q[idx]};
  endfunction

  assign {qa_ready, qa_data} = lookup(qa_tag);
  assign {qb_ready, qb_data} = lookup(qb_tag);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ready_d    = ready_q;
    rf_valid_d = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_tag_d   = rf_tag_q;
    rf_data_d  = rf_data_q;
    bp_valid_d = 1'b0;
    bp_pc_d    = bp_pc_q;
    bp_taken_d = bp_taken_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
    if (flush_q) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ready_d = '0;
    end else begin
      if (lsb_hit) ready_d[lsb_idx] = 1'b1;
      if (alu_hit) ready_d[alu_idx] = 1'b1;
      if (commit) begin
        ready_d[head_q] = 1'b0;
        head_d          = head_q + IDX_W'(1);
        rf_valid_d      = norm_commit && (rd_q[head_q] != '0);
        rf_rd_d         = rd_q[head_q];
        rf_tag_d        = head_tag;
        rf_data_d       = data_q[head_q];
        if (br_q[head_q]) begin
          bp_valid_d = 1'b1;
          bp_pc_d    = pc_q[head_q];
          bp_taken_d = taken_q[head_q];
          if (taken_q[head_q] != pred_q[head_q]) begin
            flush_d    = 1'b1;
            flush_pc_d = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + XLEN'(4);
          end
        end
      end
      if (alloc_fire) begin
        ready_d[tail_q] = 1'b0;
        tail_d          = tail_q + IDX_W'(1);
      end
      count_d = count_q + TAG_W'(alloc_fire) - TAG_W'(commit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ready_q    <= '0;
      rf_valid_q <= 1'b0;
      rf_rd_q    <= '0;
      rf_tag_q   <= '0;
      rf_data_q  <= '0;
      bp_valid_q <= 1'b0;
      bp_pc_q    <= '0;
      bp_taken_q <= 1'b0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (rdy) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      rf_valid_q <= rf_valid_d;
      rf_rd_q    <= rf_rd_d;
      rf_tag_q   <= rf_tag_d;
      rf_data_q  <= rf_data_d;
      bp_valid_q <= bp_valid_d;
      bp_pc_q    <= bp_pc_d;
      bp_taken_q <= bp_taken_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Payload storage needs no reset: the ready bits alone say whether it is meaningful.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush_q) begin
      if (lsb_hit) data_q[lsb_idx] <= lsb_data;
      if (alu_hit) begin
        data_q[alu_idx]   <= alu_data;
        taken_q[alu_idx]  <= alu_taken;
        target_q[alu_idx] <= alu_target;
      end
      if (alloc_fire) begin
        pc_q[tail_q]    <= alloc_pc;
        rd_q[tail_q]    <= alloc_rd;
        br_q[tail_q]    <= alloc_is_branch;
        st_q[tail_q]    <= alloc_is_store;
        pred_q[tail_q]  <= alloc_pred_taken;
        taken_q[tail_q] <= 1'b0;
      end
    end
  end

  assign rf_valid = rf_valid_q;
  assign rf_rd    = rf_rd_q;
  assign rf_tag   = rf_tag_q;
  assign rf_data  = rf_data_q;
  assign bp_valid = bp_valid_q;
  assign bp_pc    = bp_pc_q;
  assign bp_taken = bp_taken_q;
  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;

endmodule

// File: tb/tb_rob_param.sv
// Testbench for rob_param: scenario tasks with inline checks plus a commit scoreboard
// that is filled at dispatch and drained as register-file writes appear.
module tb_rob_param;
  localparam int DEPTH = 16;
  localparam int TAG_W = 5;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic full;
  logic alloc_valid = 0, alloc_is_branch = 0, alloc_is_store = 0, alloc_pred_taken = 0;
  logic [XLEN-1:0] alloc_pc = '0;
  logic [REG_W-1:0] alloc_rd = '0;
  logic [TAG_W-1:0] alloc_tag;
  logic [TAG_W-1:0] qa_tag = '0, qb_tag = '0;
  logic qa_ready, qb_ready;
  logic [XLEN-1:0] qa_data, qb_data;
  logic alu_valid = 0, alu_taken = 0, lsb_valid = 0, st_done = 0;
  logic [TAG_W-1:0] alu_tag = '0, lsb_tag = '0;
  logic [XLEN-1:0] alu_data = '0, alu_target = '0, lsb_data = '0;
  logic st_commit_req;
  logic [TAG_W-1:0] st_commit_tag, rf_tag;
  logic rf_valid, bp_valid, bp_taken, flush;
  logic [REG_W-1:0] rf_rd;
  logic [XLEN-1:0] rf_data, bp_pc, flush_pc;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } exp_t;

  exp_t expQ[$];
  int vectors = 0, miscompares = 0;
  logic [XLEN-1:0] modelData [1:DEPTH];

  rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .full(full),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_rd(alloc_rd),
    .alloc_is_branch(alloc_is_branch), .alloc_is_store(alloc_is_store),
    .alloc_pred_taken(alloc_pred_taken), .alloc_tag(alloc_tag),
    .qa_tag(qa_tag), .qb_tag(qb_tag), .qa_ready(qa_ready), .qb_ready(qb_ready),
    .qa_data(qa_data), .qb_data(qb_data),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data),
    .alu_taken(alu_taken), .alu_target(alu_target),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_data(lsb_data),
    .st_commit_req(st_commit_req), .st_commit_tag(st_commit_tag), .st_done(st_done),
    .rf_valid(rf_valid), .rf_rd(rf_rd), .rf_tag(rf_tag), .rf_data(rf_data),
    .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  // Every register-file write must match the oldest outstanding expected commit.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && rf_valid === 1'b1) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL rf_commit_unexpected: got rd=%0d tag=%0d data=%h, expected no write",
                 rf_rd, rf_tag, rf_data);
      end else begin
        e = expQ.pop_front();
        if ({rf_rd, rf_tag, rf_data} !== {e.rd, e.tag, e.data}) begin
          miscompares++;
          $display("[TB] FAIL rf_commit: got rd=%0d tag=%0d data=%h, expected rd=%0d tag=%0d data=%h",
                   rf_rd, rf_tag, rf_data, e.rd, e.tag, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alu_valid = 0; lsb_valid = 0; st_done = 0;
    alu_tag = '0; lsb_tag = '0; qa_tag = '0; qb_tag = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    step();
    step();
    expQ.delete();
    rst = 1'b0;
  endtask

  task automatic pushExp(input int rd, input int tag, input logic [XLEN-1:0] data);
    exp_t e;
    e.rd = REG_W'(rd);
    e.tag = TAG_W'(tag);
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic allocOne(input logic [XLEN-1:0] pc, input int rd,
                          input logic br, input logic st, input logic pred);
    alloc_valid = 1; alloc_pc = pc; alloc_rd = REG_W'(rd);
    alloc_is_branch = br; alloc_is_store = st; alloc_pred_taken = pred;
    step();
    alloc_valid = 0;
  endtask

  task automatic aluWb(input int tag, input logic [XLEN-1:0] data,
                       input logic taken, input logic [XLEN-1:0] target);
    alu_valid = 1; alu_tag = TAG_W'(tag); alu_data = data;
    alu_taken = taken; alu_target = target;
    step();
    alu_valid = 0;
  endtask

  task automatic waitQueue(input int target, input int maxCycles, input string name);
    int n = 0;
    while (expQ.size() > target && n < maxCycles) begin
      step();
      n++;
    end
    vectors++;
    if (expQ.size() > target) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: got %0d pending commits, expected %0d", name, expQ.size(), target);
    end
  endtask

  task automatic test_reset();
    doReset();
    vectors += 7;
    if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    if (alloc_tag !== 5'd1) begin miscompares++; $display("[TB] FAIL reset_alloc_tag: got %0d expected 1", alloc_tag); end
    if (rf_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rf_valid: got %b expected 0", rf_valid); end
    if (bp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bp_valid: got %b expected 0", bp_valid); end
    if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flush: got %b expected 0", flush); end
    if (flush_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_flush_pc: got %h expected 0", flush_pc); end
    if (st_commit_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_st_req: got %b expected 0", st_commit_req); end
  endtask

  task automatic test_fill_wrap();
    int ord[16] = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 16, 15, 14, 13, 12, 11};
    doReset();
    for (int i = 1; i <= DEPTH; i++) begin
      vectors += 2;
      if (alloc_tag !== TAG_W'(i)) begin miscompares++; $display("[TB] FAIL fill_alloc_tag: got %0d expected %0d", alloc_tag, i); end
      if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_not_full: got %b expected 0 at alloc %0d", full, i); end
      modelData[i] = 32'h1000 + i;
      pushExp(i, i, modelData[i]);
      allocOne(32'(i * 4), i, 0, 0, 0);
    end
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
    allocOne(32'h999, 3, 0, 0, 0);
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_full: got %b expected 1", full); end
    for (int i = 1; i <= 10; i++) aluWb(i, modelData[i], 0, '0);
    waitQueue(6, 50, "drain10");
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_full: got %b expected 0", full); end
    for (int i = 1; i <= 10; i++) begin
      vectors++;
      if (alloc_tag !== TAG_W'(i)) begin miscompares++; $display("[TB] FAIL wrap_alloc_tag: got %0d expected %0d", alloc_tag, i); end
      modelData[i] = 32'h2000 + i;
      pushExp(20 + i, i, modelData[i]);
      allocOne(32'h800 + 32'(i * 4), 20 + i, 0, 0, 0);
    end
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_full: got %b expected 1", full); end
    for (int k = 0; k < 16; k += 2) begin
      alu_valid = 1; alu_tag = TAG_W'(ord[k]); alu_data = modelData[ord[k]];
      lsb_valid = 1; lsb_tag = TAG_W'(ord[k+1]); lsb_data = modelData[ord[k+1]];
      step();
      alu_valid = 0; lsb_valid = 0;
    end
    waitQueue(0, 60, "wrap_drain");
  endtask

  task automatic test_commit();
    doReset();
    pushExp(5, 1, 32'hDEAD);
    allocOne(32'h40, 5, 0, 0, 0);
    aluWb(1, 32'hDEAD, 0, '0);
    vectors++;
    if (rf_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL commit_early: got %b expected 0", rf_valid); end
    step();
    vectors += 6;
    if (rf_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL commit_rf_valid: got %b expected 1", rf_valid); end
    if (rf_rd !== 5'd5) begin miscompares++; $display("[TB] FAIL commit_rf_rd: got %0d expected 5", rf_rd); end
    if (rf_tag !== 5'd1) begin miscompares++; $display("[TB] FAIL commit_rf_tag: got %0d expected 1", rf_tag); end
    if (rf_data !== 32'hDEAD) begin miscompares++; $display("[TB] FAIL commit_rf_data: got %h expected dead", rf_data); end
    if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL commit_full: got %b expected 0", full); end
    if (alloc_tag !== 5'd2) begin miscompares++; $display("[TB] FAIL commit_alloc_tag: got %0d expected 2", alloc_tag); end
    step();
    vectors++;
    if (rf_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL commit_pulse: got %b expected 0", rf_valid); end
    waitQueue(0, 5, "commit");
  endtask

  task automatic test_query();
    doReset();
    for (int i = 0; i < 3; i++) allocOne(32'h60 + 32'(i * 4), 0, 0, 0, 0);
    qa_tag = 5'd3; alu_valid = 1; alu_tag = 5'd3; alu_data = 32'h55;
    #1;
    vectors += 2;
    if (qa_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL query_alu_ready: got %b expected 1", qa_ready); end
    if (qa_data !== 32'h55) begin miscompares++; $display("[TB] FAIL query_alu_data: got %h expected 55", qa_data); end
    qa_tag = 5'd0;
    #1;
    vectors += 2;
    if (qa_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL query_tag0_ready: got %b expected 0", qa_ready); end
    if (qa_data !== 32'h0) begin miscompares++; $display("[TB] FAIL query_tag0_data: got %h expected 0", qa_data); end
    alu_valid = 0; qa_tag = 5'd3; qb_tag = 5'd2; lsb_valid = 1; lsb_tag = 5'd2; lsb_data = 32'h77;
    #1;
    vectors += 3;
    if (qa_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL query_stored_notready: got %b expected 0", qa_ready); end
    if (qb_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL query_lsb_ready: got %b expected 1", qb_ready); end
    if (qb_data !== 32'h77) begin miscompares++; $display("[TB] FAIL query_lsb_data: got %h expected 77", qb_data); end
    alu_valid = 1; alu_tag = 5'd2; alu_data = 32'h11; lsb_data = 32'h22;
    #1;
    vectors++;
    if (qb_data !== 32'h11) begin miscompares++; $display("[TB] FAIL query_priority: got %h expected 11", qb_data); end
    alu_valid = 0; lsb_valid = 0;
    @(posedge clk); #1;
    lsb_valid = 1; lsb_tag = 5'd2; lsb_data = 32'h99;
    step();
    lsb_valid = 0;
    #1;
    vectors += 2;
    if (qb_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL query_stored_ready: got %b expected 1", qb_ready); end
    if (qb_data !== 32'h99) begin miscompares++; $display("[TB] FAIL query_stored_data: got %h expected 99", qb_data); end
    idle();
  endtask

  task automatic test_store();
    doReset();
    pushExp(9, 2, 32'hABC);
    allocOne(32'h80, 4, 0, 1, 0);
    allocOne(32'h84, 9, 0, 0, 0);
    aluWb(2, 32'hABC, 0, '0);
    for (int c = 0; c < 3; c++) begin
      vectors += 3;
      if (st_commit_req !== 1'b1) begin miscompares++; $display("[TB] FAIL store_req: got %b expected 1", st_commit_req); end
      if (st_commit_tag !== 5'd1) begin miscompares++; $display("[TB] FAIL store_tag: got %0d expected 1", st_commit_tag); end
      if (rf_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL store_wait_rf: got %b expected 0", rf_valid); end
      step();
    end
    st_done = 1;
    step();
    st_done = 0;
    vectors += 2;
    if (st_commit_req !== 1'b0) begin miscompares++; $display("[TB] FAIL store_retired_req: got %b expected 0", st_commit_req); end
    if (rf_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL store_no_rf: got %b expected 0", rf_valid); end
    step();
    vectors += 2;
    if (rf_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL store_next_rf_valid: got %b expected 1", rf_valid); end
    if (rf_tag !== 5'd2) begin miscompares++; $display("[TB] FAIL store_next_rf_tag: got %0d expected 2", rf_tag); end
    waitQueue(0, 5, "store");
  endtask

  task automatic test_branch();
    doReset();
    allocOne(32'h100, 0, 1, 0, 0);
    allocOne(32'h104, 3, 0, 0, 0);
    aluWb(2, 32'h33, 0, '0);
    aluWb(1, 32'h0, 1, 32'h200);
    vectors += 2;
    if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL br_early_flush: got %b expected 0", flush); end
    if (bp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL br_early_bp: got %b expected 0", bp_valid); end
    step();
    vectors += 6;
    if (bp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL br_bp_valid: got %b expected 1", bp_valid); end
    if (bp_pc !== 32'h100) begin miscompares++; $display("[TB] FAIL br_bp_pc: got %h expected 100", bp_pc); end
    if (bp_taken !== 1'b1) begin miscompares++; $display("[TB] FAIL br_bp_taken: got %b expected 1", bp_taken); end
    if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL br_flush: got %b expected 1", flush); end
    if (flush_pc !== 32'h200) begin miscompares++; $display("[TB] FAIL br_flush_pc: got %h expected 200", flush_pc); end
    if (rf_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL br_rf_valid: got %b expected 0", rf_valid); end
    allocOne(32'h500, 6, 0, 0, 0);
    vectors += 5;
    if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL br_flush_pulse: got %b expected 0", flush); end
    if (bp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL br_bp_pulse: got %b expected 0", bp_valid); end
    if (flush_pc !== 32'h200) begin miscompares++; $display("[TB] FAIL br_flush_pc_hold: got %h expected 200", flush_pc); end
    if (alloc_tag !== 5'd1) begin miscompares++; $display("[TB] FAIL br_recover_tag: got %0d expected 1", alloc_tag); end
    if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL br_recover_full: got %b expected 0", full); end
    step();
    vectors++;
    if (rf_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL br_discard_rf: got %b expected 0", rf_valid); end
    allocOne(32'h300, 0, 1, 0, 0);
    allocOne(32'h400, 0, 1, 0, 1);
    aluWb(1, 32'h0, 0, 32'h999);
    aluWb(2, 32'h0, 0, 32'h888);
    vectors += 4;
    if (bp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL br2_bp_valid: got %b expected 1", bp_valid); end
    if (bp_pc !== 32'h300) begin miscompares++; $display("[TB] FAIL br2_bp_pc: got %h expected 300", bp_pc); end
    if (bp_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL br2_bp_taken: got %b expected 0", bp_taken); end
    if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL br2_no_flush: got %b expected 0", flush); end
    step();
    vectors += 3;
    if (bp_pc !== 32'h400) begin miscompares++; $display("[TB] FAIL br3_bp_pc: got %h expected 400", bp_pc); end
    if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL br3_flush: got %b expected 1", flush); end
    if (flush_pc !== 32'h404) begin miscompares++; $display("[TB] FAIL br3_flush_pc: got %h expected 404", flush_pc); end
    step();
  endtask

  task automatic test_rdy_hold();
    doReset();
    allocOne(32'h10, 7, 0, 0, 0);
    rdy = 0;
    alu_valid = 1; alu_tag = 5'd1; alu_data = 32'h77;
    alloc_valid = 1; alloc_rd = 5'd8;
    repeat (3) step();
    alu_valid = 0; alloc_valid = 0;
    vectors += 2;
    if (alloc_tag !== 5'd2) begin miscompares++; $display("[TB] FAIL rdy_alloc_tag: got %0d expected 2", alloc_tag); end
    if (rf_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rdy_rf_valid: got %b expected 0", rf_valid); end
    rdy = 1;
    step();
    step();
    qa_tag = 5'd1;
    #1;
    vectors += 2;
    if (rf_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rdy_dropped_wb: got %b expected 0", rf_valid); end
    if (qa_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rdy_entry_ready: got %b expected 0", qa_ready); end
    qa_tag = 5'd0;
    pushExp(7, 1, 32'h88);
    aluWb(1, 32'h88, 0, '0);
    waitQueue(0, 5, "rdy");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_fill_wrap();
    test_commit();
    test_query();
    test_store();
    test_branch();
    test_rdy_hold();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
